fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch front end: owns the PC, issues reads to the sync instruction memory,
//  buffers returned words, and hands {instr, pc+4} to the IF/ID register over valid/ready.
//  Sits directly upstream of IF/ID. Redirects from the EX/MEM branch decision and decode
//  stalls (out_ready=0) are absorbed here, so IF/ID only sees correct-path, in-order words.
// PARAMETERS
//  ADDR_W      32   PC / memory address width
//  DATA_W      32   instruction width
//  RESET_PC    0    first fetch address after reset
//  DEPTH       2    instruction buffer entries (>=2 needed for 1 instr/cycle)
// PORTS
//  clk            in   1       rising-edge clock
//  rst_n          in   1       asynchronous active-low reset
//  imem_req       out  1       read request this cycle
//  imem_addr      out  ADDR_W  read address (= PC), bits[1:0] always 0
//  imem_rdata     in   DATA_W  read data, valid exactly 1 cycle after imem_req
//  redirect_valid in   1       branch taken: discard wrong path, restart at redirect_pc
//  redirect_pc    in   ADDR_W  redirect target; bits[1:0] ignored (forced 0)
//  out_valid      out  1       out_instr/out_pc_plus4 valid toward IF/ID
//  out_ready      in   1       IF/ID accepts (0 = decode stall)
//  out_instr      out  DATA_W  instruction at buffer head
//  out_pc_plus4   out  ADDR_W  address of that instruction + 4
// BEHAVIOUR
//  - Reset (async, rst_n=0): PC=RESET_PC, buffer empty, no in-flight read, state=BOOT;
//    imem_req=0, out_valid=0, out_instr=0, out_pc_plus4=0. Outputs stay 0 while rst_n=0.
//  - FSM: BOOT -> RUN (unconditional, 1 cycle, no request);
//    RUN -> REDIR on redirect_valid; REDIR -> RUN (1 bubble cycle, no request).
//    redirect_valid in BOOT or REDIR also loads PC and stays/enters REDIR.
//  - Request (RUN only): imem_req = (count + inflight - pop) < DEPTH, no redirect_valid;
//    pop = out_valid & out_ready. On request PC <= PC+4 (mod 2^ADDR_W; 0xFFFFFFFC -> 0).
//  - Response: inflight=1 registered on request; next cycle imem_rdata is pushed with
//    tag = address+4. Credit rule guarantees no push into a full buffer (assert it).
//  - Output: head of FIFO; out_valid = (count!=0) & ~redirect_valid. Transfer on
//    out_valid&out_ready. Held stable while out_valid & ~out_ready.
//  - Simultaneous push+pop: count unchanged, order preserved.
//  - Redirect (cycle R): buffer cleared, in-flight response arriving in R or R+1 dropped,
//    PC <= {redirect_pc[ADDR_W-1:2],2'b00} at end of R; REDIR in R+1; first request
//    to target in R+2; its word visible (out_valid=1) in R+4. Pop in R is suppressed.
//  - Latency: rst_n rises before cycle 0: cycle0 BOOT, cycle1 req RESET_PC, cycle2 data
//    returns, cycle3 out_valid=1. Steady state with out_ready=1: one instruction/cycle.
//  - Reset mid-operation: everything returns to reset values immediately; any late
//    imem_rdata after reset release is ignored (inflight cleared).
// TESTING
//  1 Reset, RESET_PC=0, mem[i]=0x1000_0000+i, out_ready=1 -> out_valid first in cycle 3,
//    instr 0x10000000/pc+4 4, then 0x10000001/8 ... one per cycle, no gaps.
//  2 out_ready=0 for 5 cycles mid-stream -> at most DEPTH words buffered, imem_req=0 once
//    full, head held stable; release -> sequence resumes with no loss or duplication.
//  3 redirect_valid=1, redirect_pc=0x0000_0043 while 2 words buffered and 1 in flight ->
//    none delivered after R; next delivered word is mem[0x40>>2], pc_plus4=0x44, in R+4.
//  4 RESET_PC=0xFFFF_FFF8 -> words at 0xFFFFFFF8, 0xFFFFFFFC, 0x0 with pc_plus4
//    0xFFFFFFFC, 0x0, 0x4.
//  5 Redirect same cycle as out_ready=1 and count=1 -> no transfer (out_valid=0 in R).
//  6 Drop rst_n mid-stream with data in flight -> outputs 0 asynchronously; after
//    release, fetch restarts at RESET_PC, stale rdata never appears on out_instr.

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// fetch_stage : PC owner, sync-imem requester and in-order instruction buffer
// Revision    : 1.0
// ============================================================================
module fetch_stage #(
    parameter int                  ADDR_W   = 32,
    parameter int                  DATA_W   = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0,
    parameter int                  DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [DATA_W-1:0]   imem_rdata,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_instr,
    output logic [ADDR_W-1:0]   out_pc_plus4
);

    localparam int               PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]      DEPTH_V = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0]    LAST    = PW'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PC_INIT = {RESET_PC[ADDR_W-1:2], 2'b00};

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        REDIR = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   pc;
    logic                inflight;
    logic [DATA_W-1:0]   buf_instr [DEPTH];
    logic [ADDR_W-1:0]   buf_pc4   [DEPTH];
    logic [PW-1:0]       rd_ptr, wr_ptr;
    logic [CW-1:0]       count;
    logic                req, push, pop, not_empty;
    logic [CW:0]         credit_used;
    logic                unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign not_empty = (count != '0);
    assign pop       = out_valid & out_ready;
    // A response arriving in the redirect cycle belongs to the wrong path.
    assign push      = inflight & ~redirect_valid;
    // Words already owned (buffered + in flight) after this cycle's pop.
    assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};

    always_comb begin
        state_next = state;
        req        = 1'b0;
        case (state)
            BOOT:    state_next = redirect_valid ? REDIR : RUN;
            RUN: begin
                if (redirect_valid) begin
                    state_next = REDIR;
                end else begin
                    req = (credit_used < DEPTH_V);
                end
            end
            REDIR:   state_next = redirect_valid ? REDIR : RUN;
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            pc       <= PC_INIT;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state <= state_next;
            if (redirect_valid) begin
                pc       <= {redirect_pc[ADDR_W-1:2], 2'b00};
                inflight <= 1'b0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                inflight <= req;
                if (req) begin
                    pc <= pc + ADDR_W'(4);
                end
                if (push) begin
                    wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

    // Only one read is ever outstanding and pc has already advanced past it,
    // so pc is the tag (address + 4) of the word arriving now.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wr_ptr] <= imem_rdata;
            buf_pc4[wr_ptr]   <= pc;
        end
    end

    assign imem_req     = req;
    assign imem_addr    = pc;
    assign out_valid    = not_empty & ~redirect_valid;
    assign out_instr    = not_empty ? buf_instr[rd_ptr] : '0;
    assign out_pc_plus4 = not_empty ? buf_pc4[rd_ptr]   : '0;

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && ({1'b0, count} == DEPTH_V)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// Directed bench for fetch_stage: a synchronous memory model returns
// 0x1000_0000 + (addr >> 2) for a request and 0xDEADBEEF otherwise.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n, rst2_n;
    logic        imem_req, imem_req2;
    logic [31:0] imem_addr, imem_addr2;
    logic [31:0] imem_rdata, imem_rdata2;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, out_valid2;
    logic        out_ready;
    logic        out_ready2 = 1'b1;
    logic [31:0] out_instr, out_instr2;
    logic [31:0] out_pc_plus4, out_pc_plus42;

    int n_pass  = 0;
    int n_total = 0;
    int exp_idx = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    always @(posedge clk) begin
        imem_rdata  <= imem_req  ? memf(imem_addr)  : 32'hDEAD_BEEF;
        imem_rdata2 <= imem_req2 ? memf(imem_addr2) : 32'hDEAD_BEEF;
    end

    fetch_stage #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc_plus4(out_pc_plus4)
    );

    fetch_stage #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
        .clk(clk), .rst_n(rst2_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rdata(imem_rdata2), .redirect_valid(1'b0), .redirect_pc(32'h0),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_instr(out_instr2),
        .out_pc_plus4(out_pc_plus42)
    );

    task automatic test_reset;
        rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) @(posedge clk);
        #2;
        n_total++; if ({imem_req, out_valid} !== 2'b00) $display("FAIL reset_req_valid got %b exp 00", {imem_req, out_valid}); else n_pass++;
        n_total++; if (out_instr !== 32'h0) $display("FAIL reset_instr got %h exp 0", out_instr); else n_pass++;
        n_total++; if (out_pc_plus4 !== 32'h0) $display("FAIL reset_pc4 got %h exp 0", out_pc_plus4); else n_pass++;
        rst_n = 1'b1;
        #1;
        n_total++; if (imem_req !== 1'b0) $display("FAIL boot_no_req got %b exp 0", imem_req); else n_pass++;
    endtask

    // Cycles 1..10 after reset release: first word in cycle 3, then one per cycle.
    task automatic test_stream;
        @(posedge clk); #2;
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL first_req got req=%b addr=%h exp 1/0", imem_req, imem_addr); else n_pass++;
        @(posedge clk); #2;
        n_total++; if (out_valid !== 1'b0) $display("FAIL cycle2_valid got %b exp 0", out_valid); else n_pass++;
        exp_idx = 0;
        for (int c = 3; c <= 10; c++) begin
            @(posedge clk); #2;
            n_total++;
            if (out_valid !== 1'b1 || out_instr !== 32'h1000_0000 + exp_idx || out_pc_plus4 !== (exp_idx + 1) * 4)
                $display("FAIL stream c%0d got v=%b %h/%h exp 1 %h/%h", c, out_valid, out_instr, out_pc_plus4,
                         32'h1000_0000 + exp_idx, (exp_idx + 1) * 4);
            else n_pass++;
            exp_idx++;
        end
    endtask

    task automatic test_stall;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1 out_ready = 1'b0; #1;
            n_total++;
            if (out_valid !== 1'b1 || imem_req !== 1'b0 || out_instr !== 32'h1000_0000 + exp_idx)
                $display("FAIL stall c%0d got v=%b req=%b %h exp 1 0 %h", c, out_valid, imem_req, out_instr, 32'h1000_0000 + exp_idx);
            else n_pass++;
        end
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1 out_ready = 1'b1; #1;
            n_total++;
            if (out_valid !== 1'b1 || out_instr !== 32'h1000_0000 + exp_idx || out_pc_plus4 !== (exp_idx + 1) * 4)
                $display("FAIL resume c%0d got v=%b %h/%h exp 1 %h/%h", c, out_valid, out_instr, out_pc_plus4,
                         32'h1000_0000 + exp_idx, (exp_idx + 1) * 4);
            else n_pass++;
            exp_idx++;
        end
    endtask

    // Fill the buffer under a stall, then redirect to an unaligned target.
    task automatic test_redirect_buffered;
        repeat (2) begin
            @(posedge clk); #1 out_ready = 1'b0; #1;
        end
        @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h0000_0043; #1;
        n_total++; if (out_valid !== 1'b0 || imem_req !== 1'b0) $display("FAIL redir_R got v=%b req=%b exp 0 0", out_valid, imem_req); else n_pass++;
        @(posedge clk); #1 redirect_valid = 1'b0; out_ready = 1'b1; #1;
        n_total++; if (out_valid !== 1'b0 || imem_req !== 1'b0) $display("FAIL redir_R1 got v=%b req=%b exp 0 0", out_valid, imem_req); else n_pass++;
        @(posedge clk); #2;
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || out_valid !== 1'b0) $display("FAIL redir_R2 got req=%b addr=%h v=%b exp 1 40 0", imem_req, imem_addr, out_valid); else n_pass++;
        @(posedge clk); #2;
        n_total++; if (out_valid !== 1'b0) $display("FAIL redir_R3 got v=%b exp 0", out_valid); else n_pass++;
        @(posedge clk); #2;
        n_total++; if (out_valid !== 1'b1 || out_instr !== 32'h1000_0010 || out_pc_plus4 !== 32'h44) $display("FAIL redir_R4 got v=%b %h/%h exp 1 10000010/44", out_valid, out_instr, out_pc_plus4); else n_pass++;
        @(posedge clk); #2;
        n_total++; if (out_valid !== 1'b1 || out_instr !== 32'h1000_0011 || out_pc_plus4 !== 32'h48) $display("FAIL redir_R5 got v=%b %h/%h exp 1 10000011/48", out_valid, out_instr, out_pc_plus4); else n_pass++;
        exp_idx = 32'h12;
    endtask

    // Redirect while one word is offered with out_ready=1 and one is in flight.
    task automatic test_redirect_pop;
        repeat (2) begin
            @(posedge clk); #2;
            n_total++;
            if (out_valid !== 1'b1 || out_instr !== 32'h1000_0000 + exp_idx) $display("FAIL pre_redir got v=%b %h exp 1 %h", out_valid, out_instr, 32'h1000_0000 + exp_idx);
            else n_pass++;
            exp_idx++;
        end
        @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL pop_redir_R got v=%b exp 0", out_valid); else n_pass++;
        @(posedge clk); #1 redirect_valid = 1'b0; #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL pop_redir_R1 got v=%b exp 0", out_valid); else n_pass++;
        @(posedge clk); #2;
        n_total++; if (out_valid !== 1'b0 || imem_addr !== 32'h100 || imem_req !== 1'b1) $display("FAIL pop_redir_R2 got v=%b req=%b addr=%h exp 0 1 100", out_valid, imem_req, imem_addr); else n_pass++;
        @(posedge clk); #2;
        n_total++; if (out_valid !== 1'b0) $display("FAIL pop_redir_R3 got v=%b exp 0", out_valid); else n_pass++;
        @(posedge clk); #2;
        n_total++; if (out_valid !== 1'b1 || out_instr !== 32'h1000_0040 || out_pc_plus4 !== 32'h104) $display("FAIL pop_redir_R4 got v=%b %h/%h exp 1 10000040/104", out_valid, out_instr, out_pc_plus4); else n_pass++;
        @(posedge clk); #2;
        n_total++; if (out_valid !== 1'b1 || out_instr !== 32'h1000_0041 || out_pc_plus4 !== 32'h108) $display("FAIL pop_redir_R5 got v=%b %h/%h exp 1 10000041/108", out_valid, out_instr, out_pc_plus4); else n_pass++;
    endtask

    task automatic test_wrap;
        logic [31:0] exp_i [3];
        logic [31:0] exp_p [3];
        exp_i[0] = 32'h4FFF_FFFE; exp_p[0] = 32'hFFFF_FFFC;
        exp_i[1] = 32'h4FFF_FFFF; exp_p[1] = 32'h0000_0000;
        exp_i[2] = 32'h1000_0000; exp_p[2] = 32'h0000_0004;
        @(posedge clk); #2 rst2_n = 1'b1;
        @(posedge clk); #2;
        n_total++; if (imem_req2 !== 1'b1 || imem_addr2 !== 32'hFFFF_FFF8) $display("FAIL wrap_first_req got req=%b addr=%h exp 1 fffffff8", imem_req2, imem_addr2); else n_pass++;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #2;
            n_total++;
            if (out_valid2 !== 1'b1 || out_instr2 !== exp_i[k] || out_pc_plus42 !== exp_p[k])
                $display("FAIL wrap_word%0d got v=%b %h/%h exp 1 %h/%h", k, out_valid2, out_instr2, out_pc_plus42, exp_i[k], exp_p[k]);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({imem_req, out_valid} !== 2'b00 || out_instr !== 32'h0 || out_pc_plus4 !== 32'h0)
            $display("FAIL async_reset got req=%b v=%b %h/%h exp 0 0 0/0", imem_req, out_valid, out_instr, out_pc_plus4);
        else n_pass++;
        @(posedge clk); #2;
        n_total++; if (out_valid !== 1'b0 || out_instr !== 32'h0) $display("FAIL reset_hold got v=%b %h exp 0 0", out_valid, out_instr); else n_pass++;
        rst_n = 1'b1;
        #1;
        n_total++; if (imem_req !== 1'b0 || out_instr !== 32'h0) $display("FAIL rst_boot got req=%b %h exp 0 0", imem_req, out_instr); else n_pass++;
        @(posedge clk); #2;
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || out_instr !== 32'h0) $display("FAIL rst_restart got req=%b addr=%h instr=%h exp 1 0 0", imem_req, imem_addr, out_instr); else n_pass++;
        @(posedge clk); #2;
        n_total++; if (out_valid !== 1'b0 || out_instr !== 32'h0) $display("FAIL rst_stale got v=%b %h exp 0 0", out_valid, out_instr); else n_pass++;
        @(posedge clk); #2;
        n_total++; if (out_valid !== 1'b1 || out_instr !== 32'h1000_0000 || out_pc_plus4 !== 32'h4) $display("FAIL rst_first_word got v=%b %h/%h exp 1 10000000/4", out_valid, out_instr, out_pc_plus4); else n_pass++;
    endtask

    initial begin
        rst2_n = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_buffered();
        test_redirect_pop();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
